// File: rtl/sort_sequencer_if.sv
// Host-side and compare-swap bus for sort_sequencer.
//
// Handshake: the host drives start for at least one cycle while busy=0. The
// sequencer takes start as accepted on the first rising edge where it is in
// IDLE. It then holds busy=1 until the end of the single cycle in which done=1.
// start and wr_en are ignored while busy=1, and nothing is queued.
interface sort_sequencer_if #(
    parameter int W  = 8,
    parameter int AW = 3
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          start;
    logic          desc;
    logic          busy;
    logic          done;
    logic [15:0]   swap_count;
    logic [W-1:0]  cs_a;
    logic [W-1:0]  cs_b;
    logic [W-1:0]  cs_lo;
    logic [W-1:0]  cs_hi;
    logic [1:0]    dbg_state;

    // Host side, which also hosts the external compare-swap unit
    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, start, desc, cs_lo, cs_hi,
        input  rd_data, busy, done, swap_count, cs_a, cs_b, dbg_state
    );

    // Sequencer side
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, start, desc, cs_lo, cs_hi,
        output rd_data, busy, done, swap_count, cs_a, cs_b, dbg_state
    );
endinterface

// File: rtl/sort_sequencer.sv
// In-place bubble sort of a 2**AW entry register array.
// An external combinational compare-swap unit does the comparisons. The sort
// ends early when a pass makes no swaps.
module sort_sequencer #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    sort_sequencer_if.slave    bus
);
    localparam int N = 1 << AW;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CMP      = 2'd1;
    localparam logic [1:0] S_PASS_END = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    // Highest j in pass 0. Later passes stop one entry earlier each.
    localparam logic [AW-1:0] LAST_J = AW'(N - 2);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  mem_q [N];
    logic [W-1:0]  mem_d [N];
    logic [AW-1:0] j_q, j_d;
    logic [AW-1:0] pass_q, pass_d;
    logic          swapped_q, swapped_d;
    logic          desc_q, desc_d;
    logic [15:0]   count_q, count_d;
    logic [W-1:0]  rd_data_q, rd_data_d;

    logic [AW-1:0] j_p1;
    logic          is_swap;

    assign j_p1 = j_q + 1'b1;

    // Operands always reflect the current pair; they are only used in CMP
    assign bus.cs_a = mem_q[j_q];
    assign bus.cs_b = mem_q[j_p1];

    // Whether the pair is out of order for the latched direction (equal never swaps)
    assign is_swap = desc_q ? (bus.cs_a < bus.cs_b) : (bus.cs_a > bus.cs_b);

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.swap_count = count_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.dbg_state  = state_q;

    // Next-state logic for the sequencer FSM, array and counters
    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        j_d       = j_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
        desc_d    = desc_q;
        count_d   = count_q;
        rd_data_d = mem_q[bus.rd_addr];

        case (state_q)
            S_IDLE: begin
                // A write and a start in the same cycle: the write lands first
                if (bus.wr_en) begin
                    mem_d[bus.wr_addr] = bus.wr_data;
                end
                if (bus.start) begin
                    desc_d    = bus.desc;
                    count_d   = '0;
                    j_d       = '0;
                    pass_d    = '0;
                    swapped_d = 1'b0;
                    state_d   = S_CMP;
                end
            end
            S_CMP: begin
                mem_d[j_q]  = desc_q ? bus.cs_hi : bus.cs_lo;
                mem_d[j_p1] = desc_q ? bus.cs_lo : bus.cs_hi;
                if (is_swap) begin
                    swapped_d = 1'b1;
                    count_d   = count_q + 16'd1;
                end
                if (j_q == (LAST_J - pass_q)) begin
                    state_d = S_PASS_END;
                end else begin
                    j_d = j_p1;
                end
            end
            S_PASS_END: begin
                if (!swapped_q || (pass_q == LAST_J)) begin
                    state_d = S_DONE;
                end else begin
                    pass_d    = pass_q + 1'b1;
                    j_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = S_CMP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that clears the whole array
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            j_q       <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
            desc_q    <= 1'b0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            j_q       <= j_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
            desc_q    <= desc_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end
endmodule

// File: doc/sort_sequencer.md
Name: sort_sequencer

Overview:
- Controller that sequences a shared 8-bit combinational compare-and-swap unit to bubble-sort a small internal register array in place.
- The host loads values serially, pulses start, waits for done, then reads the sorted values back.
- The compare-swap unit sits outside this block: this block drives its operands and captures its min/max results.
- Supports ascending or descending order and early exit when a pass makes no swaps.

Parameters:
W, 8, data width of each entry and of the compare-swap operands.
AW, 3, address width; array depth N = 2**AW (AW >= 1).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  array write strobe; honoured only when busy=0.
wr_addr  in  AW  write index.
wr_data  in  W  write value.
rd_addr  in  AW  read index.
rd_data  out  W  registered read value of mem[rd_addr]; 1-cycle latency.
start  in  1  begin a sort; sampled only in IDLE.
desc  in  1  sort order, latched on accepted start: 0 = ascending, 1 = descending.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse in the DONE state.
swap_count  out  16  swaps performed in the current/last sort; cleared on accepted start.
cs_a  out  W  compare-swap operand A; equals mem[j].
cs_b  out  W  compare-swap operand B; equals mem[j+1].
cs_lo  in  W  min(cs_a, cs_b) from the external unit (combinational).
cs_hi  in  W  max(cs_a, cs_b) from the external unit (combinational).

Behaviour:
- Reset: state=IDLE; busy=0, done=0, swap_count=0, rd_data=0; all mem entries=0; j=0, pass=0, swapped flag=0. Reset wins over every other input, including mid-sort.
- cs_a/cs_b are combinational from mem[j]/mem[j+1]. They are valid in all states; they are consumed only in CMP.
- IDLE:
  - wr_en writes mem[wr_addr].
  - start=1 latches desc, clears swap_count, sets j=0, pass=0, swapped=0, then goes to CMP.
  - If start and wr_en occur in the same cycle, the write is performed and then the sort begins.
- CMP (one comparison per cycle):
  - Ascending: mem[j] <= cs_lo, mem[j+1] <= cs_hi. A swap is counted when cs_a > cs_b.
  - Descending: mem[j] <= cs_hi, mem[j+1] <= cs_lo. A swap is counted when cs_a < cs_b.
  - On a swap: swapped <= 1, swap_count++ (wraps at 16 bits).
  - Equal values never swap.
  - If j == N-2-pass, go to PASS_END; otherwise j++.
- PASS_END (one cycle):
  - If swapped==0 or pass==N-2, go to DONE.
  - Otherwise pass++, j=0, swapped=0, go to CMP.
- DONE (one cycle): done=1, then go to IDLE. busy is still 1 in this cycle.
- While busy=1: wr_en and start are ignored, with no queuing.
- rd_data is readable in any state. During a sort it returns the intermediate array contents.
- Latency, with start accepted at cycle T:
  - Already-sorted input: CMP at T+1..T+N-1, PASS_END at T+N, done at T+N+1.
  - Worst case: N(N-1)/2 CMP cycles + (N-1) PASS_END cycles, with done one cycle later.
  - For N=8: sorted input gives done at T+9; reverse-sorted input gives done at T+36.
- N=2 degenerate case: a single pass with one CMP, then PASS_END, then DONE.

Test Plan:
1. Load 67,111,147,25,89,28,40,154 into addr 0..7, start with desc=0 -> done pulses once; reads give 25,28,40,67,89,111,147,154; swap_count=13; busy high from T+1 through the done cycle.
2. Load 1..8 ascending, start with desc=0 -> no swaps; done exactly at T+9; swap_count=0; contents unchanged.
3. Load 8,7,...,1, start with desc=0 -> done at T+36; swap_count=28; contents 1..8. Same data with desc=1 -> done at T+9; swap_count=0.
4. Load 245,128,154,120,242,114,139,233, start with desc=1 -> contents 245,242,233,154,139,128,120,114. Also load all entries 90 -> done at T+9, swap_count=0.
5. During a busy sort, assert wr_en (addr 0, data 0xFF) and start -> both ignored; final contents and done timing match the run without them.
6. Assert rst at T+5 of a sort -> next cycle busy=0, done=0, swap_count=0, all reads return 0; a fresh load+start then sorts correctly.
